// File: rtl/jtframe_sdram_pkg.sv
// Shared encodings for the SDRAM round-robin arbiter: FSM states, the
// "no byte masked" constant and the slot-index width helper.
package jtframe_sdram_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMD  = 2'd1,
      DATA = 2'd2
   } arb_state_t;

   // Byte mask is active low, so reads present both bytes enabled
   localparam logic [1:0] MASK_NONE = 2'b11;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/jtframe_rr_pick.sv
// Combinational round-robin selector: first active request at or after ptr,
// wrapping around, returned both one-hot and as an index.
module jtframe_rr_pick #(
   parameter int N  = 4,
   parameter int IW = 2
)(
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx,
   output logic          any
);

   always_comb begin
      int            k;
      logic [IW-1:0] ks;
      gnt = '0;
      idx = '0;
      any = 1'b0;
      k   = 0;
      ks  = '0;
      for (int i = 0; i < N; i++) begin
         k = int'(ptr) + i;
         if (k >= N) k = k - N;
         ks = IW'(k);
         if (!any && req[ks]) begin
            any     = 1'b1;
            gnt[ks] = 1'b1;
            idx     = ks;
         end
      end
   end

endmodule

// File: rtl/jtframe_sdram_rr_arb.sv
// Round-robin arbiter sharing one SDRAM controller port among N requesters.
// Optional watchdog enabled by defining JTFRAME_SDRAM_ARB_TOUT_EN.
module jtframe_sdram_rr_arb
   import jtframe_sdram_pkg::*;
#(
   parameter int N      = 4,
   parameter int SDRAMW = 22,
   parameter int TOUT   = 255
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [N-1:0]          req,
   input  logic [N-1:0]          req_rnw,
   input  logic [N*SDRAMW-1:0]   req_addr,
   input  logic [N*16-1:0]       req_din,
   input  logic [N*2-1:0]        req_wrmask,
   output logic [N-1:0]          gnt,
   output logic [N-1:0]          done,
   output logic                  busy,
   output logic                  sdram_rd,
   output logic                  sdram_wr,
   output logic [SDRAMW-1:0]     sdram_addr,
   output logic [15:0]           data_write,
   output logic [1:0]            sdram_wrmask,
   input  logic                  sdram_ack,
   input  logic                  data_rdy,
   output logic                  tout_err
);

   localparam int IW = idx_w(N);

   if (N < 2 || N > 8 || TOUT < 1 || TOUT > 255) begin : g_bad_param
      $error("jtframe_sdram_rr_arb: N must be 2..8 and TOUT 1..255");
   end

   arb_state_t    st;
   logic [IW-1:0] ptr;
   logic [IW-1:0] pick_idx;
   logic [N-1:0]  pick_gnt;
   logic          pick_any;
   logic          finish;
   logic          timeout;

   jtframe_rr_pick #(
      .N   ( N        ),
      .IW  ( IW       )
   ) u_pick (
      .req ( req      ),
      .ptr ( ptr      ),
      .gnt ( pick_gnt ),
      .idx ( pick_idx ),
      .any ( pick_any )
   );

   // A controller that accepts and completes in one cycle skips DATA entirely
   assign finish = (st == DATA && data_rdy) || (st == CMD && sdram_ack && data_rdy);

`ifdef JTFRAME_SDRAM_ARB_TOUT_EN
   logic [7:0] wd;
   logic       tout_r;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd     <= '0;
         tout_r <= 1'b0;
      end else if (st == IDLE) begin
         wd <= '0;
      end else begin
         wd <= wd + 8'd1;
         if (timeout && !finish) tout_r <= 1'b1;
      end
   end

   assign timeout  = (wd == 8'(TOUT - 1));
   assign tout_err = tout_r;
`else
   assign timeout  = 1'b0;
   assign tout_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st           <= IDLE;
         gnt          <= '0;
         done         <= '0;
         busy         <= 1'b0;
         sdram_rd     <= 1'b0;
         sdram_wr     <= 1'b0;
         sdram_addr   <= '0;
         data_write   <= '0;
         sdram_wrmask <= MASK_NONE;
         ptr          <= '0;
      end else begin
         done <= '0;
         case (st)
            IDLE: begin
               if (pick_any) begin
                  st         <= CMD;
                  gnt        <= pick_gnt;
                  busy       <= 1'b1;
                  ptr        <= (pick_idx == IW'(N - 1)) ? '0 : pick_idx + 1'b1;
                  sdram_addr <= req_addr[pick_idx*SDRAMW +: SDRAMW];
                  data_write <= req_din[pick_idx*16 +: 16];
                  if (req_rnw[pick_idx]) begin
                     sdram_rd     <= 1'b1;
                     sdram_wrmask <= MASK_NONE;
                  end else begin
                     sdram_wr     <= 1'b1;
                     sdram_wrmask <= req_wrmask[pick_idx*2 +: 2];
                  end
               end
            end
            CMD, DATA: begin
               if (finish) begin
                  st       <= IDLE;
                  done     <= gnt;
                  gnt      <= '0;
                  busy     <= 1'b0;
                  sdram_rd <= 1'b0;
                  sdram_wr <= 1'b0;
               end else if (timeout) begin
                  // Abandon silently: the requester never sees done
                  st       <= IDLE;
                  gnt      <= '0;
                  busy     <= 1'b0;
                  sdram_rd <= 1'b0;
                  sdram_wr <= 1'b0;
               end else if (st == CMD && sdram_ack) begin
                  st       <= DATA;
                  sdram_rd <= 1'b0;
                  sdram_wr <= 1'b0;
               end
            end
            default: begin
               st   <= IDLE;
               gnt  <= '0;
               busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/jtframe_sdram_rr_arb.md
JTFRAME_SDRAM_RR_ARB -- requirements
Module: jtframe_sdram_rr_arb

Interface
REQ-001 Parameter N, default 4, SHALL set the number of requesters (2..8).
REQ-002 Parameter SDRAMW, default 22, SHALL set the SDRAM word-address width.
REQ-003 Parameter TOUT, default 255, SHALL set the watchdog limit in clk cycles (8-bit counter).
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 Ports SHALL be:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req  in  N  per-slot request, held high until done
- req_rnw  in  N  per-slot 1=read, 0=write
- req_addr  in  N*SDRAMW  per-slot address, slot k at [k*SDRAMW +: SDRAMW]
- req_din  in  N*16  per-slot write data
- req_wrmask  in  N*2  per-slot byte mask, active low
- gnt  out  N  one-hot grant
- done  out  N  one-cycle completion pulse
- busy  out  1  transaction in flight
- sdram_rd  out  1  read strobe to controller
- sdram_wr  out  1  write strobe to controller
- sdram_addr  out  SDRAMW  latched address
- data_write  out  16  latched write data
- sdram_wrmask  out  2  latched mask; 2'b11 for reads
- sdram_ack  in  1  controller accepted command
- data_rdy  in  1  controller finished read or write
- tout_err  out  1  sticky watchdog flag (macro only)

Function
REQ-006 FSM SHALL have states IDLE, CMD, DATA.
REQ-007 In IDLE with any req high at edge t, the arbiter SHALL at t+1 enter CMD, assert exactly one gnt bit, latch addr/din/wrmask from that slot, and assert sdram_rd (rnw=1) or sdram_wr (rnw=0).
REQ-008 Selection SHALL be round-robin: search starts at slot ptr, ptr resets to 0 and becomes (granted+1) mod N on each grant.
REQ-009 In CMD, sdram_rd/sdram_wr SHALL stay high until the cycle sdram_ack is sampled, then drop and FSM SHALL go to DATA.
REQ-010 In DATA, on data_rdy the arbiter SHALL pulse done[granted] for one cycle, clear gnt and busy, and return to IDLE; next grant no earlier than the following cycle.
REQ-011 sdram_ack and data_rdy in the same cycle during CMD SHALL be treated as completion (REQ-010 applies directly).
REQ-012 data_rdy or sdram_ack sampled in IDLE SHALL be ignored without state change.
REQ-013 Deasserting req of the granted slot mid-transaction SHALL NOT abort it; done still pulses.
REQ-014 busy SHALL equal (state != IDLE).
REQ-015 sdram_addr, data_write, sdram_wrmask SHALL remain stable from grant until done.
REQ-016 A slot held requesting SHALL be granted within N transactions.

Reset
REQ-017 On rst_n low, asynchronously: state=IDLE, gnt=0, done=0, busy=0, sdram_rd=0, sdram_wr=0, sdram_addr=0, data_write=0, sdram_wrmask=2'b11, ptr=0, tout_err=0, watchdog=0.
REQ-018 Reset during CMD or DATA SHALL abandon the transaction with no done pulse.

Configuration
REQ-019 Macro JTFRAME_SDRAM_ARB_TOUT_EN SHALL enable the watchdog: counter clears on grant, counts in CMD/DATA; reaching TOUT forces IDLE, clears gnt, pulses no done, sets tout_err until reset.
REQ-020 Without the macro, no counter exists, tout_err SHALL be tied 0, and the FSM waits indefinitely.

Structure
REQ-021 State encodings (IDLE/CMD/DATA) and the mask constant 2'b11 SHALL live in shared package jtframe_sdram_pkg.
REQ-022 One sub-module jtframe_rr_pick (N-bit request, ptr in, one-hot grant and index out, combinational) SHALL implement selection.

Verification
REQ-023 Single read: req=4'b0001, rnw=1, addr=0x1234; ack at +3, data_rdy at +6 -> sdram_rd 1 for 3 cycles, sdram_addr=0x1234, wrmask=11, done[0] one pulse.
REQ-024 Write: slot2 din=0xBEEF mask=2'b01 -> sdram_wr high until ack, data_write=0xBEEF, sdram_wrmask=01, done[2] pulse.
REQ-025 All four req held high continuously -> grant order 0,1,2,3,0 with one IDLE cycle between transactions.
REQ-026 ack and data_rdy same cycle in CMD -> done pulses that cycle, IDLE next.
REQ-027 rst_n low during DATA -> all outputs at reset values immediately, no done pulse, ptr=0.
REQ-028 Macro on, TOUT=16, never send data_rdy -> gnt clears at cycle 16 after grant, tout_err=1, next slot granted.
